// File: rtl/instruction_decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decode_if
//  Description : Bundle between the fetch stage and the instruction decoder.
//                Fetch side drives the instruction word and its byte address;
//                the decoder returns the decoded fields and a redirect request.
//  Modports    : master - fetch / stimulus side (drives i_*, observes o_*)
//                slave  - decoder side (observes i_*, drives o_*)
//  Revision    : 1.0 - initial release
// ============================================================================
interface instruction_decode_if;
    logic [31:0] i_instruction;
    logic [15:0] i_process_counter;

    logic        o_en_jmp;
    logic [15:0] o_jmp_address;
    logic        o_valid;
    logic        o_illegal;
    logic [6:0]  o_opcode;
    logic [4:0]  o_rd;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [31:0] o_imm;
    logic [15:0] o_pc;

    modport master (
        output i_instruction, i_process_counter,
        input  o_en_jmp, o_jmp_address, o_valid, o_illegal, o_opcode, o_rd,
               o_rs1, o_rs2, o_funct3, o_funct7, o_imm, o_pc
    );

    modport slave (
        input  i_instruction, i_process_counter,
        output o_en_jmp, o_jmp_address, o_valid, o_illegal, o_opcode, o_rd,
               o_rs1, o_rs2, o_funct3, o_funct7, o_imm, o_pc
    );
endinterface
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decode
//  Description : Single-cycle RV32I instruction decoder. Splits the fetched
//                word into raw fields, builds the sign-extended immediate,
//                flags illegal words and redirects fetch on JAL. After a
//                taken JAL the next FLUSH_CYCLES fetched words are dropped
//                because they were already in flight in the fetch stage.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                bus  - instruction_decode_if.slave (fetch word/pc in,
//                       decoded fields, illegal flag and redirect out)
//  Parameters  : FLUSH_CYCLES - words discarded after a taken jump
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode #(
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    instruction_decode_if.slave     bus
);

    // A zero-length flush still needs a 1-bit counter to keep widths legal.
    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] c_flush_load = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_fence  = 7'b0001111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic        r_en_jmp;
    logic [15:0] r_jmp_address;
    logic        r_valid;
    logic        r_illegal;
    logic [6:0]  r_opcode;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [31:0] r_imm;
    logic [15:0] r_pc;

    // ------------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------------
    logic [31:0] w_ins;
    logic [6:0]  w_opcode;
    logic        w_known_op;
    logic [31:0] w_imm;
    logic [31:0] w_imm_j;
    logic [15:0] w_jal_target;
    logic        w_is_jal;
    logic        w_jal_ok;
    logic        w_jal_bad;
    logic        w_live;
    logic        w_illegal;

    assign w_ins    = bus.i_instruction;
    assign w_opcode = w_ins[6:0];
    assign w_imm_j  = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20],
                       w_ins[30:21], 1'b0};

    // Target is 16-bit wrap-around; immediate bits above 15 cannot matter.
    assign w_jal_target = bus.i_process_counter + w_imm_j[15:0];

    always_comb begin
        w_known_op = 1'b0;
        w_imm      = 32'h0;
        case (w_opcode)
            c_op_imm, c_op_load, c_op_jalr, c_op_system: begin
                w_known_op = 1'b1;
                w_imm      = {{20{w_ins[31]}}, w_ins[31:20]};
            end
            c_op_store: begin
                w_known_op = 1'b1;
                w_imm      = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            end
            c_op_branch: begin
                w_known_op = 1'b1;
                w_imm      = {{19{w_ins[31]}}, w_ins[31], w_ins[7],
                              w_ins[30:25], w_ins[11:8], 1'b0};
            end
            c_op_lui, c_op_auipc: begin
                w_known_op = 1'b1;
                w_imm      = {w_ins[31:12], 12'h000};
            end
            c_op_jal: begin
                w_known_op = 1'b1;
                w_imm      = w_imm_j;
            end
            c_op_reg, c_op_fence: begin
                w_known_op = 1'b1;
                w_imm      = 32'h0;
            end
            default: begin
                w_known_op = 1'b0;
                w_imm      = 32'h0;
            end
        endcase
    end

    always_comb begin
        w_is_jal  = (w_opcode == c_op_jal);
        // bit[1] set means the target is not word aligned.
        w_jal_bad = w_is_jal && w_jal_target[1];
        w_jal_ok  = w_is_jal && !w_jal_target[1];
        // Every listed opcode ends in 2'b11, so a known opcode implies it.
        w_live    = (w_ins != 32'h0) && w_known_op && !w_jal_bad;
        w_illegal = (w_ins != 32'h0) && (!w_known_op || w_jal_bad);
    end

    // ------------------------------------------------------------------------
    // State machine and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_RUN;
            r_cnt         <= '0;
            r_en_jmp      <= 1'b0;
            r_jmp_address <= 16'h0;
            r_valid       <= 1'b0;
            r_illegal     <= 1'b0;
            r_opcode      <= 7'h0;
            r_rd          <= 5'h0;
            r_rs1         <= 5'h0;
            r_rs2         <= 5'h0;
            r_funct3      <= 3'h0;
            r_funct7      <= 7'h0;
            r_imm         <= 32'h0;
            r_pc          <= 16'h0;
        end else begin
            // Bubble outputs unless a live word is decoded below.
            r_en_jmp      <= 1'b0;
            r_jmp_address <= 16'h0;
            r_valid       <= 1'b0;
            r_illegal     <= 1'b0;
            r_opcode      <= 7'h0;
            r_rd          <= 5'h0;
            r_rs1         <= 5'h0;
            r_rs2         <= 5'h0;
            r_funct3      <= 3'h0;
            r_funct7      <= 7'h0;
            r_imm         <= 32'h0;
            r_pc          <= 16'h0;

            case (r_state)
                S_RUN: begin
                    r_illegal <= w_illegal;
                    if (w_live) begin
                        r_valid  <= 1'b1;
                        r_opcode <= w_opcode;
                        r_rd     <= w_ins[11:7];
                        r_rs1    <= w_ins[19:15];
                        r_rs2    <= w_ins[24:20];
                        r_funct3 <= w_ins[14:12];
                        r_funct7 <= w_ins[31:25];
                        r_imm    <= w_imm;
                        r_pc     <= bus.i_process_counter;
                    end
                    // Only JAL redirects; branches and JALR are resolved later.
                    if (w_jal_ok) begin
                        r_en_jmp      <= 1'b1;
                        r_jmp_address <= w_jal_target;
                        if (FLUSH_CYCLES > 0) begin
                            r_state <= S_FLUSH;
                            r_cnt   <= c_flush_load;
                        end
                    end
                end

                S_FLUSH: begin
                    // Word on the bus is stale fetch; drop it.
                    if (r_cnt <= c_cnt_one) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.o_en_jmp      = r_en_jmp;
    assign bus.o_jmp_address = r_jmp_address;
    assign bus.o_valid       = r_valid;
    assign bus.o_illegal     = r_illegal;
    assign bus.o_opcode      = r_opcode;
    assign bus.o_rd          = r_rd;
    assign bus.o_rs1         = r_rs1;
    assign bus.o_rs2         = r_rs2;
    assign bus.o_funct3      = r_funct3;
    assign bus.o_funct7      = r_funct7;
    assign bus.o_imm         = r_imm;
    assign bus.o_pc          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_decode
//  Description : Directed self-checking bench for instruction_decode with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    int   n_pulses;

    instruction_decode_if bus_if ();

    instruction_decode #(.FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a word on the falling edge, let it be captured, sample #1 later.
    task automatic step(input logic [31:0] ins, input logic [15:0] pc);
        @(negedge clk);
        bus_if.i_instruction     = ins;
        bus_if.i_process_counter = pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        n_pulses = 0;
        rst = 1'b0;
        bus_if.i_instruction     = 32'h0;
        bus_if.i_process_counter = 16'h0;

        // Reset held 10 cycles with empty fetch.
        repeat (10) @(posedge clk);
        #1;
        chk("rst_valid",   {31'h0, bus_if.o_valid},   32'h0);
        chk("rst_en_jmp",  {31'h0, bus_if.o_en_jmp},  32'h0);
        chk("rst_illegal", {31'h0, bus_if.o_illegal}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(32'h0, 16'h0);
        step(32'h0, 16'h0);
        chk("idle_valid",  {31'h0, bus_if.o_valid}, 32'h0);
        chk("idle_opcode", {25'h0, bus_if.o_opcode}, 32'h0);
        chk("idle_imm",    bus_if.o_imm, 32'h0);
        chk("idle_pc",     {16'h0, bus_if.o_pc}, 32'h0);

        // addi x2, x0, 14
        step(32'h00E00113, 16'd4);
        chk("addi_valid",  {31'h0, bus_if.o_valid},  32'h1);
        chk("addi_opcode", {25'h0, bus_if.o_opcode}, 32'h13);
        chk("addi_rd",     {27'h0, bus_if.o_rd},     32'd2);
        chk("addi_rs1",    {27'h0, bus_if.o_rs1},    32'd0);
        chk("addi_funct3", {29'h0, bus_if.o_funct3}, 32'd0);
        chk("addi_imm",    bus_if.o_imm,             32'd14);
        chk("addi_pc",     {16'h0, bus_if.o_pc},     32'd4);
        chk("addi_en_jmp", {31'h0, bus_if.o_en_jmp}, 32'h0);

        // lui x0, 0x12345
        step(32'h12345037, 16'd8);
        chk("lui_imm",    bus_if.o_imm, 32'h12345000);
        chk("lui_opcode", {25'h0, bus_if.o_opcode}, 32'h37);

        // beq x0, x0, +8 : decoded, no redirect
        step(32'h00000463, 16'd12);
        chk("beq_valid",  {31'h0, bus_if.o_valid},  32'h1);
        chk("beq_imm",    bus_if.o_imm, 32'd8);
        chk("beq_en_jmp", {31'h0, bus_if.o_en_jmp}, 32'h0);

        // jal x1, +16 at pc 8 -> target 24, then two words flushed
        step(32'h010000EF, 16'd8);
        chk("jal_en_jmp", {31'h0, bus_if.o_en_jmp}, 32'h1);
        chk("jal_addr",   {16'h0, bus_if.o_jmp_address}, 32'd24);
        chk("jal_rd",     {27'h0, bus_if.o_rd}, 32'd1);
        chk("jal_imm",    bus_if.o_imm, 32'd16);
        chk("jal_valid",  {31'h0, bus_if.o_valid}, 32'h1);
        step(32'h00000013, 16'd12);
        chk("fl1_valid",  {31'h0, bus_if.o_valid},  32'h0);
        chk("fl1_en_jmp", {31'h0, bus_if.o_en_jmp}, 32'h0);
        chk("fl1_addr",   {16'h0, bus_if.o_jmp_address}, 32'h0);
        step(32'h00000013, 16'd16);
        chk("fl2_valid",  {31'h0, bus_if.o_valid}, 32'h0);
        step(32'h00E00113, 16'd24);
        chk("tgt_valid",  {31'h0, bus_if.o_valid}, 32'h1);
        chk("tgt_pc",     {16'h0, bus_if.o_pc}, 32'd24);

        // jal x0, -8 at pc 4 -> wraps to 0xFFFC
        step(32'hFF9FF06F, 16'd4);
        chk("jneg_en_jmp", {31'h0, bus_if.o_en_jmp}, 32'h1);
        chk("jneg_addr",   {16'h0, bus_if.o_jmp_address}, 32'h0000FFFC);
        chk("jneg_imm",    bus_if.o_imm, 32'hFFFFFFF8);
        step(32'h0, 16'hFFFC);
        step(32'h0, 16'h0);

        // Illegal opcode: one-cycle flag
        step(32'hFFFFFFFF, 16'h40);
        chk("ill_flag",  {31'h0, bus_if.o_illegal}, 32'h1);
        chk("ill_valid", {31'h0, bus_if.o_valid},   32'h0);
        step(32'h0, 16'h44);
        chk("ill_clear", {31'h0, bus_if.o_illegal}, 32'h0);

        // Back-to-back JALs: exactly one redirect pulse
        step(32'h010000EF, 16'd8);
        n_pulses += int'(bus_if.o_en_jmp);
        step(32'h010000EF, 16'd12);
        n_pulses += int'(bus_if.o_en_jmp);
        step(32'h0, 16'd16);
        n_pulses += int'(bus_if.o_en_jmp);
        step(32'h0, 16'd24);
        n_pulses += int'(bus_if.o_en_jmp);
        chk("jal2_pulses", 32'(n_pulses), 32'd1);

        // Misaligned JAL: pc 10 + 16 = 26, bit[1] set
        step(32'h010000EF, 16'd10);
        chk("mis_illegal", {31'h0, bus_if.o_illegal}, 32'h1);
        chk("mis_valid",   {31'h0, bus_if.o_valid},   32'h0);
        chk("mis_en_jmp",  {31'h0, bus_if.o_en_jmp}, 32'h0);
        step(32'h00E00113, 16'd14);
        chk("mis_next_valid", {31'h0, bus_if.o_valid}, 32'h1);

        // Reset during flush aborts it
        step(32'h010000EF, 16'd8);
        chk("rf_en_jmp", {31'h0, bus_if.o_en_jmp}, 32'h1);
        @(negedge clk);
        bus_if.i_instruction     = 32'h0;
        bus_if.i_process_counter = 16'h0;
        rst = 1'b0;
        #1;
        chk("rf_async_en_jmp", {31'h0, bus_if.o_en_jmp}, 32'h0);
        chk("rf_async_valid",  {31'h0, bus_if.o_valid},  32'h0);
        chk("rf_async_rd",     {27'h0, bus_if.o_rd},     32'h0);
        chk("rf_async_imm",    bus_if.o_imm,             32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(32'h00E00113, 16'd20);
        chk("rf_post_valid", {31'h0, bus_if.o_valid}, 32'h1);
        chk("rf_post_pc",    {16'h0, bus_if.o_pc},    32'd20);
        chk("rf_post_imm",   bus_if.o_imm,            32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
